// File: rtl/sr_mem_arbiter_pkg.sv
// Shared types and constants for the I/D single-port memory arbiter.
package sr_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } owner_e;

  localparam logic [3:0] FETCH_BE = 4'hF;
  localparam int STREAK_W = 4;
  localparam logic [STREAK_W-1:0] STREAK_MAX = '1;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sr_arb_fair_pick.sv
// Data-priority owner select with a bounded D streak so a pending fetch
// is never starved for more than D_MAX_STREAK consecutive data grants.
module sr_arb_fair_pick
  import sr_mem_arbiter_pkg::*;
#(
  parameter int D_MAX_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic                d_req,
  input  logic                grant,
  input  logic [1:0]          owner,
  output logic [1:0]          pick,
  output logic [STREAK_W-1:0] streak
);

  localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(D_MAX_STREAK);

  logic [STREAK_W-1:0] streak_q, streak_d;

  always_comb begin
    pick = NONE;
    if (d_req && !(i_req && streak_q == LIMIT)) begin
      pick = OWN_D;
    end else if (i_req) begin
      pick = OWN_I;
    end
  end

  // Only D grants that actually delayed a pending fetch extend the streak.
  always_comb begin
    streak_d = streak_q;
    if (grant) begin
      if (owner == OWN_D && i_req) begin
        streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
      end else begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  assign streak = streak_q;

endmodule

// File: rtl/sr_mem_arbiter.sv
// Fetch/data arbiter onto one single-port memory, one transaction in flight.
// Define SR_MEM_ARBITER_PERF_EN to add saturating grant/stall counters.
module sr_mem_arbiter
  import sr_mem_arbiter_pkg::*;
#(
  parameter int AW           = 32,
  parameter int D_MAX_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  input  logic [3:0]    d_be,
  output logic          d_ack,
  output logic [31:0]   d_rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  output logic [3:0]    m_be,
  input  logic          m_gnt,
  input  logic          m_rvalid,
  input  logic [31:0]   m_rdata
`ifdef SR_MEM_ARBITER_PERF_EN
  ,
  output logic [31:0]   perf_i_grants,
  output logic [31:0]   perf_d_grants,
  output logic [31:0]   perf_i_stall
`endif
);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                m_req_q, m_req_d;
  logic                m_we_q, m_we_d;
  logic [AW-1:0]       m_addr_q, m_addr_d;
  logic [31:0]         m_wdata_q, m_wdata_d;
  logic [3:0]          m_be_q, m_be_d;
  logic [1:0]          pick;
  logic                grant;
  logic                resp;
  logic [STREAK_W-1:0] unused_streak;

  assign grant = (state_q == IDLE) && (pick != NONE);

  // Streak is exposed by the picker for debug visibility only.
  sr_arb_fair_pick #(
    .D_MAX_STREAK(D_MAX_STREAK)
  ) u_pick (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req (i_req),
    .d_req (d_req),
    .grant (grant),
    .owner (pick),
    .pick  (pick),
    .streak(unused_streak)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_be_d    = m_be_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          owner_d = owner_e'(pick);
          state_d = REQ;
          m_req_d = 1'b1;
          if (pick == OWN_D) begin
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_be_d    = d_be;
          end else begin
            m_we_d    = 1'b0;
            m_addr_d  = i_addr;
            m_wdata_d = '0;
            m_be_d    = FETCH_BE;
          end
        end
      end
      REQ: begin
        if (m_gnt) begin
          m_req_d = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (m_rvalid) begin
          state_d = IDLE;
          owner_d = NONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= NONE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_be_q    <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_be_q    <= m_be_d;
    end
  end

  // Response strobes outside WAIT are stray and never produce an ack.
  assign resp    = (state_q == WAIT) && m_rvalid;
  assign i_ack   = resp && (owner_q == OWN_I);
  assign d_ack   = resp && (owner_q == OWN_D);
  assign i_rdata = i_ack ? m_rdata : '0;
  assign d_rdata = d_ack ? m_rdata : '0;

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_be    = m_be_q;

`ifdef SR_MEM_ARBITER_PERF_EN
  logic [31:0] perf_i_grants_q, perf_d_grants_q, perf_i_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_i_grants_q <= '0;
      perf_d_grants_q <= '0;
      perf_i_stall_q  <= '0;
    end else begin
      if (grant && pick == OWN_I) perf_i_grants_q <= sat_inc32(perf_i_grants_q);
      if (grant && pick == OWN_D) perf_d_grants_q <= sat_inc32(perf_d_grants_q);
      if (i_req && !i_ack)        perf_i_stall_q  <= sat_inc32(perf_i_stall_q);
    end
  end

  assign perf_i_grants = perf_i_grants_q;
  assign perf_d_grants = perf_d_grants_q;
  assign perf_i_stall  = perf_i_stall_q;
`endif

endmodule

// File: doc/sr_mem_arbiter.md
Name: sr_mem_arbiter

Overview:
- Shares one single-port memory between the CPU instruction-fetch port (I) and the load/store data port (D). This lets the CPU run against a unified memory.
- Grants are data-priority with a bounded fetch-starvation guarantee.
- At most one memory transaction is outstanding at a time. Each requester holds its request until it receives a one-cycle acknowledge.

Parameters:
- AW, 32, address width in bits for all ports.
- D_MAX_STREAK, 4, maximum consecutive D grants while i_req is pending; the next grant then goes to I. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; held until i_ack
- i_addr  in  AW  fetch word address
- i_ack  out  1  one-cycle fetch completion
- i_rdata  out  32  fetch data; valid when i_ack=1
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  32  store data
- d_be  in  4  store byte enables
- d_ack  out  1  one-cycle data completion
- d_rdata  out  32  load data; valid when d_ack=1
- m_req  out  1  memory request; held until m_gnt
- m_we  out  1  memory write enable
- m_addr  out  AW  memory address
- m_wdata  out  32  memory write data
- m_be  out  4  memory byte enables; 4'hF for fetches
- m_gnt  in  1  memory accepted the request this cycle
- m_rvalid  in  1  response strobe, for reads and writes alike
- m_rdata  in  32  memory read data

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, owner=NONE, streak=0.
  - m_req/m_we/m_addr/m_wdata/m_be all 0; i_ack=d_ack=0.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - If no request, stay in IDLE.
  - Otherwise pick an owner:
    - only one request pending: pick it.
    - both pending: pick D unless streak==D_MAX_STREAK, then pick I.
  - Register the owner's addr/we/wdata/be into the m_* outputs. Fetches drive we=0, be=4'hF, wdata=0.
  - Go to REQ.
- REQ:
  - m_req=1, with m_* held stable.
  - On m_gnt=1: drop m_req next cycle and go to WAIT.
- WAIT:
  - m_req=0.
  - On m_rvalid=1: the owner's ack=1 combinationally in that same cycle, with its rdata = m_rdata; the other rdata is 0.
  - Then return to IDLE.
- Streak counter:
  - On a D grant while i_req=1: streak+1, saturating at 15.
  - On an I grant, or any D grant while i_req=0: streak cleared.
- Latency:
  - req seen in IDLE at cycle N, m_req at N+1.
  - With m_gnt at N+1 and m_rvalid at N+2, ack is at N+2.
  - Minimum request-to-ack is 2 cycles. Throughput is at most one transaction per 3 cycles.
- Requester rule: req is still high in the ack cycle. The requester must drop it, or present a new request, in the cycle after ack. Any req seen in IDLE is a new transaction.
- Ignored inputs:
  - m_rvalid in IDLE or REQ.
  - m_gnt in IDLE or WAIT.
- Request changes after selection are ignored until the following IDLE. The latched m_* values are used.
- Reset mid-transaction: the FSM returns to IDLE immediately. A late m_rvalid after reset is ignored and no ack is produced.
- Simultaneous i_req and d_req rising in the same IDLE cycle: the tie-break rule above applies.

Optional Feature:
- Macro SR_MEM_ARBITER_PERF_EN.
- When defined, adds three outputs, each 32-bit, saturating at 32'hFFFF_FFFF, reset to 0:
  - perf_i_grants: counts I grants.
  - perf_d_grants: counts D grants.
  - perf_i_stall: counts cycles with i_req=1 and i_ack=0.
- When undefined, these ports and counters do not exist. Arbitration behaviour is identical in both builds.

Decomposition:
- Package sr_mem_arbiter_pkg:
  - state enum {IDLE, REQ, WAIT}.
  - owner enum {NONE, OWN_I, OWN_D}.
  - constants for the fetch byte-enable (4'hF) and streak counter width (4).
- One sub-module, sr_arb_fair_pick: combinational owner select plus the registered streak counter. Inputs are i_req, d_req, grant strobe and chosen owner; outputs are pick and streak.
- The top level holds the FSM and the m_* registers.

Test Plan:
- Fetch only, i_addr=32'h100, memory returns 32'hDEADBEEF:
  - m_req at N+1 with m_be=4'hF, m_we=0.
  - i_ack=1 with i_rdata=32'hDEADBEEF at N+2.
- Store only, d_we=1, d_addr=32'h40, d_wdata=32'h12345678, d_be=4'b0011, with m_gnt delayed 3 cycles:
  - m_req held for 3 cycles with stable fields.
  - d_ack follows m_rvalid.
  - i_ack stays 0.
- i_req and d_req held high continuously, D_MAX_STREAK=4:
  - Grant order is D,D,D,D,I,D,D,D,D,I.
- Reset asserted in WAIT, then a stray m_rvalid=1 after release:
  - No i_ack or d_ack.
  - All m_* are 0.
  - The next request is served normally.
- m_rvalid=1 injected in IDLE and m_gnt=1 injected in WAIT:
  - Both ignored, no ack, state unchanged.
- With SR_MEM_ARBITER_PERF_EN, 5 fetches plus 3 loads:
  - perf_i_grants=5, perf_d_grants=3.
  - perf_i_stall equals the counted stall cycles.
